// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory controller.
//   size_e  : request size encoding (3 is illegal and has no enumerator)
//   state_e : controller FSM states
//   req_t   : request fields held from accept until the response
//   req_err : accept-time legality check
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RWAIT,
    WR,
    RESP
  } state_e;

  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0001_0000;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  ofs;
    logic [15:0] wdata;  // sub-word stores only ever need the low half
  } req_t;

  function automatic logic req_err(input logic [1:0]  size,
                                   input logic [31:0] addr,
                                   input logic [31:0] limit);
    return (size == 2'd3) ||
           (size == SZ_HALF && addr[0]) ||
           (size == SZ_WORD && addr[1:0] != 2'b00) ||
           (addr >= limit);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane steering for sub-word accesses (little-endian lanes).
//   word_i  : word read from memory
//   data_i  : right-aligned store data (byte uses [7:0], half uses [15:0])
//   ofs_i   : byte offset addr[1:0]
//   size_i  : access size
//   sgn_i   : sign-extend loads
//   load_o  : extracted and extended load value
//   merge_o : word_i with the target lane replaced by data_i
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  ofs_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w  = word_i[8*ofs_i +: 8];
    half_w  = ofs_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o                = {{24{sgn_i & byte_w[7]}}, byte_w};
        merge_o[8*ofs_i +: 8] = data_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{sgn_i & half_w[15]}}, half_w};
        if (ofs_i[1]) merge_o[31:16] = data_i;
        else          merge_o[15:0]  = data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-wide synchronous memory with a one-cycle
// registered read. One request at a time; sub-word stores are done as
// read-modify-write. Illegal requests answer with resp_err and never strobe.
//   clk, rst_n          : clock, async active-low reset
//   req_*               : request handshake and fields (sampled on accept)
//   resp_valid/err/rdata: one-cycle response
//   mem_*               : memory interface
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_readdata
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] load_w, merge_w;

  lsu_lane u_lane (
    .word_i  (mem_readdata),
    .data_i  (req_q.wdata),
    .ofs_i   (req_q.ofs),
    .size_i  (req_q.size),
    .sgn_i   (req_q.sgn),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        req_d   = '{write: req_write, size: req_size, sgn: req_signed,
                    ofs: req_addr[1:0], wdata: req_wdata[15:0]};
        addr_d  = {req_addr[31:2], 2'b00};
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = req_err(req_size, req_addr, ADDR_LIMIT);
        if (err_d)                              state_d = RESP;
        else if (req_write && req_size == SZ_WORD) state_d = WR;
        else                                    state_d = RD;
      end
      RD:    state_d = RWAIT;
      // Read data is on mem_readdata now: either merge it for the write-back
      // or extract the load lane.
      RWAIT: begin
        if (req_q.write) begin
          wdata_d = merge_w;
          state_d = WR;
        end else begin
          rdata_d = load_w;
          state_d = RESP;
        end
      end
      WR:    state_d = RESP;
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_err      = err_q;
  assign resp_rdata    = rdata_q;
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;
  assign mem_memRead   = (state_q == RD);
  assign mem_memWrite  = (state_q == WR);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_write = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, mem_memRead, mem_memWrite;
  logic [31:0] resp_rdata, mem_address, mem_writeData;
  logic [31:0] mem_readdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite), .mem_readdata(mem_readdata)
  );

  // Synchronous word memory with registered read and a preload port.
  logic [31:0] mem [0:16383];
  logic        pl_en = 0;
  logic [13:0] pl_idx = 0;
  logic [31:0] pl_data = 0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_memWrite) mem[mem_address[15:2]] <= mem_writeData;
    if (mem_memRead) mem_readdata <= mem[mem_address[15:2]];
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mwd;
  } vec_t;

  typedef struct { logic err; logic [31:0] rdata; } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic err, input logic [31:0] rdata,
                              input logic [31:0] mwd);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
    v.err = err; v.rdata = rdata; v.mwd = mwd;
    return v;
  endfunction

  // Response monitor: pops the scoreboard on every response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_memRead && mem_memWrite) chk("strobe_overlap", 1, 0);
      if (resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
          chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    req_valid = 1; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  lat = 0, nrd = 0, nwr = 0, elat, enrd, enwr;
    bit  acc = 0;
    exp_t e;
    string nm;
    nm = $sformatf("vec%0d", idx);
    elat = v.err ? 1 : (!v.wr ? 3 : (v.sz == 2'd2 ? 2 : 4));
    enrd = (!v.err && (!v.wr || v.sz != 2'd2)) ? 1 : 0;
    enwr = (!v.err && v.wr) ? 1 : 0;
    @(negedge clk);
    drive(v);
    e.err = v.err; e.rdata = v.rdata;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin acc = 1; break; end
      @(negedge clk);
    end
    if (!acc) chk({nm, "_accept"}, 0, 1);
    @(posedge clk);
    #1 req_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_memRead) begin
        nrd++;
        chk({nm, "_rd_addr"}, {32'd0, mem_address}, {32'd0, v.addr[31:2], 2'b00});
      end
      if (mem_memWrite) begin
        nwr++;
        chk({nm, "_wr_data"}, {32'd0, mem_writeData}, {32'd0, v.mwd});
      end
      if (resp_valid) begin lat = i; break; end
    end
    if (v.err) chk({nm, "_lat"}, {63'd0, (lat == 1 || lat == 2)}, 64'd1);
    else       chk({nm, "_lat"}, lat, elat);
    chk({nm, "_nrd"}, nrd, enrd);
    chk({nm, "_nwr"}, nwr, enwr);
  endtask

  initial begin
    tbl[0]  = mk(0, 2, 0, 32'h10,    0,            0, 32'h8899AABB, 0);
    tbl[1]  = mk(0, 0, 1, 32'h13,    0,            0, 32'hFFFFFF88, 0);
    tbl[2]  = mk(0, 0, 0, 32'h13,    0,            0, 32'h00000088, 0);
    tbl[3]  = mk(0, 1, 1, 32'h12,    0,            0, 32'hFFFF8899, 0);
    tbl[4]  = mk(0, 0, 0, 32'h10,    0,            0, 32'h000000BB, 0);
    tbl[5]  = mk(0, 1, 0, 32'h12,    0,            0, 32'h00008899, 0);
    tbl[6]  = mk(1, 0, 0, 32'h11,    32'h5A,       0, 0, 32'h88995ABB);
    tbl[7]  = mk(0, 2, 0, 32'h10,    0,            0, 32'h88995ABB, 0);
    tbl[8]  = mk(0, 1, 0, 32'h11,    0,            1, 0, 0);
    tbl[9]  = mk(0, 2, 0, 32'h12,    0,            1, 0, 0);
    tbl[10] = mk(0, 3, 0, 32'h10,    0,            1, 0, 0);
    tbl[11] = mk(0, 2, 0, 32'h10000, 0,            1, 0, 0);
    tbl[12] = mk(1, 1, 0, 32'h18,    32'h0000BEEF, 0, 0, 32'h1122BEEF);
    tbl[13] = mk(1, 0, 0, 32'h1B,    32'hFFFFFF7F, 0, 0, 32'h7F22BEEF);
    tbl[14] = mk(0, 0, 1, 32'h1B,    0,            0, 32'h0000007F, 0);
    tbl[15] = mk(0, 1, 1, 32'h18,    0,            0, 32'hFFFFBEEF, 0);
    tbl[16] = mk(1, 2, 0, 32'h1C,    32'h12345678, 0, 0, 32'h12345678);
    tbl[17] = mk(0, 2, 0, 32'h1C,    0,            0, 32'h12345678, 0);
    tbl[18] = mk(1, 2, 0, 32'h22,    32'h11111111, 1, 0, 0);
    tbl[19] = mk(1, 2, 0, 32'hFFFC,  32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5);
    tbl[20] = mk(0, 2, 0, 32'hFFFC,  0,            0, 32'hA5A5A5A5, 0);
    tbl[21] = mk(1, 0, 0, 32'h10003, 32'h77,       1, 0, 0);
    tbl[22] = mk(1, 1, 0, 32'h11,    32'h1234,     1, 0, 0);

    // Reset state, checked while preloading memory.
    #1;
    chk("reset_outputs",
        {25'd0, req_ready, resp_valid, resp_err, mem_memRead, mem_memWrite,
         resp_rdata | mem_address | mem_writeData},
        {25'd0, 1'b1, 4'b0000, 32'd0});
    pl_en = 1;
    pl_idx = 14'h4; pl_data = 32'h8899AABB; @(posedge clk); #1;
    pl_idx = 14'h5; pl_data = 32'hCAFEF00D; @(posedge clk); #1;
    pl_idx = 14'h6; pl_data = 32'h11223344; @(posedge clk); #1;
    pl_en = 0;
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 23; i++) run_vec(tbl[i], i);

    // Back-to-back with req_valid held high through the busy cycles.
    begin
      exp_t e;
      @(negedge clk);
      drive(mk(1, 2, 0, 32'h20, 32'hDEADBEEF, 0, 0, 0));
      chk("hold_ready0", {63'd0, req_ready}, 64'd1);
      e.err = 0; e.rdata = 0;            sb.push_back(e);
      e.err = 0; e.rdata = 32'hDEADBEEF; sb.push_back(e);
      @(posedge clk);
      #1 drive(mk(0, 2, 0, 32'h20, 0, 0, 0, 0));
      @(negedge clk); chk("hold_busy1", {63'd0, req_ready}, 64'd0);
      @(negedge clk); chk("hold_busy2", {63'd0, req_ready}, 64'd0);
      @(negedge clk); chk("hold_idle", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1 req_valid = 0;
      repeat (6) @(negedge clk);
      chk("hold_all_resp", sb.size(), 0);
    end

    // Reset during the read phase of a half store.
    begin
      bit wr_seen = 0;
      @(negedge clk);
      drive(mk(1, 1, 0, 32'h14, 32'h0000ABCD, 0, 0, 0));
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk); chk("rst_rd_phase", {63'd0, mem_memRead}, 64'd1);
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("rst_async_outputs",
          {25'd0, req_ready, resp_valid, resp_err, mem_memRead, mem_memWrite,
           resp_rdata | mem_address | mem_writeData},
          {25'd0, 1'b1, 4'b0000, 32'd0});
      repeat (3) begin
        @(negedge clk);
        if (mem_memWrite) wr_seen = 1;
      end
      rst_n = 1;
      #1 chk("rst_ready_after", {63'd0, req_ready}, 64'd1);
      repeat (3) begin
        @(negedge clk);
        if (mem_memWrite) wr_seen = 1;
      end
      chk("rst_no_write", {63'd0, wr_seen}, 64'd0);
      chk("rst_word_kept", {32'd0, mem[5]}, {32'd0, 32'hCAFEF00D});
      run_vec(mk(0, 2, 0, 32'h14, 0, 0, 32'hCAFEF00D, 0), 99);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
